// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       zero;
    logic       memready;

    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal;
    logic       memerr;

    modport master (
        input  op, funct, rt, zero, memready,
        output iord, memwrite, irwrite, pcwrite, pcsrc, alusrca, alusrcb,
               alucontrol, regdst, memtoreg, regwrite, illegal, memerr
    );

    modport slave (
        output op, funct, rt, zero, memready,
        input  iord, memwrite, irwrite, pcwrite, pcsrc, alusrca, alusrcb,
               alucontrol, regdst, memtoreg, regwrite, illegal, memerr
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle MIPS datapath with one shared ALU and a
// unified memory port; memory states stall on memready with a timeout abort.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.master       bus
);
    localparam int unsigned WAIT_W = 8;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [2:0] ALU_SLTU = 3'b000;
    localparam logic [2:0] ALU_SUBU = 3'b001;
    localparam logic [2:0] ALU_SGE  = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;
    localparam logic [2:0] ALU_ADDU = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB,
        S_EXEC, S_ALUWB, S_BRANCH, S_IEXEC, S_IWB, S_JUMP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [WAIT_W-1:0]   r_wait;
    logic                w_memerr;
    logic                w_timeout;
    logic                w_mem_state;
    logic                w_rtype_ok;
    logic                w_branch_op;
    logic                w_imm_op;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout   = (r_wait == WAIT_W'(MEM_TIMEOUT)) && !bus.memready;
    assign w_rtype_ok  = (bus.op == OP_RTYPE) &&
                         ((bus.funct == FN_ADDU) || (bus.funct == FN_SUBU) ||
                          (bus.funct == FN_AND)  || (bus.funct == FN_OR)   ||
                          (bus.funct == FN_SLTU));
    assign w_branch_op = (bus.op == OP_BEQ) || ((bus.op == OP_REGIMM) && (bus.rt == 5'd0));
    assign w_imm_op    = (bus.op == OP_ADDIU) || (bus.op == OP_ORI) || (bus.op == OP_LUI);

    // State register and memory wait counter; counter restarts on every state entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_next;
            if ((w_state_next != r_state) || w_memerr) begin
                r_wait <= '0;
            end else if (w_mem_state && !bus.memready) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_memerr       = 1'b0;
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.pcwrite    = 1'b0;
        bus.pcsrc      = 2'b00;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.alucontrol = ALU_ADDU;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                bus.alusrcb = 2'b01;
                if (bus.memready) begin
                    bus.irwrite  = 1'b1;
                    bus.pcwrite  = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_timeout) begin
                    w_memerr     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                bus.alusrcb = 2'b11;
                if ((bus.op == OP_LW) || (bus.op == OP_SW)) begin
                    w_state_next = S_MEMADR;
                end else if (w_rtype_ok) begin
                    w_state_next = S_EXEC;
                end else if (w_branch_op) begin
                    w_state_next = S_BRANCH;
                end else if (w_imm_op) begin
                    w_state_next = S_IEXEC;
                end else if (bus.op == OP_J) begin
                    w_state_next = S_JUMP;
                end else begin
                    bus.illegal  = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_MEMADR: begin
                bus.alusrca  = 1'b1;
                bus.alusrcb  = 2'b10;
                w_state_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                if (bus.memready) begin
                    w_state_next = S_MEMWB;
                end else if (w_timeout) begin
                    w_memerr     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_MEMWR: begin
                bus.iord = 1'b1;
                // Strobe is withdrawn in the abort cycle so a timed-out store never lands.
                if (bus.memready) begin
                    bus.memwrite = 1'b1;
                    w_state_next = S_FETCH;
                end else if (w_timeout) begin
                    w_memerr     = 1'b1;
                    w_state_next = S_FETCH;
                end else begin
                    bus.memwrite = 1'b1;
                end
            end
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
                w_state_next = S_FETCH;
            end
            S_EXEC: begin
                bus.alusrca = 1'b1;
                case (bus.funct)
                    FN_SUBU: bus.alucontrol = ALU_SUBU;
                    FN_AND:  bus.alucontrol = ALU_AND;
                    FN_OR:   bus.alucontrol = ALU_OR;
                    FN_SLTU: bus.alucontrol = ALU_SLTU;
                    default: bus.alucontrol = ALU_ADDU;
                endcase
                w_state_next = S_ALUWB;
            end
            S_ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
                w_state_next = S_FETCH;
            end
            S_BRANCH: begin
                // bltz compares rs >= $0 signed; a zero result means rs < 0, i.e. taken.
                bus.alusrca    = 1'b1;
                bus.pcsrc      = 2'b01;
                bus.pcwrite    = bus.zero;
                bus.alucontrol = (bus.op == OP_BEQ) ? ALU_SUBU : ALU_SGE;
                w_state_next   = S_FETCH;
            end
            S_IEXEC: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                case (bus.op)
                    OP_ORI:  bus.alucontrol = ALU_OR;
                    OP_LUI:  bus.alucontrol = ALU_LUI;
                    default: bus.alucontrol = ALU_ADDU;
                endcase
                w_state_next = S_IWB;
            end
            S_IWB: begin
                bus.regwrite = 1'b1;
                w_state_next = S_FETCH;
            end
            S_JUMP: begin
                bus.pcsrc    = 2'b10;
                bus.pcwrite  = 1'b1;
                w_state_next = S_FETCH;
            end
            default: w_state_next = S_FETCH;
        endcase

        // Under reset: FETCH selects, every enable and pulse held low.
        if (reset) begin
            w_state_next   = S_FETCH;
            w_memerr       = 1'b0;
            bus.iord       = 1'b0;
            bus.memwrite   = 1'b0;
            bus.irwrite    = 1'b0;
            bus.pcwrite    = 1'b0;
            bus.pcsrc      = 2'b00;
            bus.alusrca    = 1'b0;
            bus.alusrcb    = 2'b01;
            bus.alucontrol = ALU_ADDU;
            bus.regdst     = 1'b0;
            bus.memtoreg   = 1'b0;
            bus.regwrite   = 1'b0;
            bus.illegal    = 1'b0;
        end

        bus.memerr = w_memerr;
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control-word checks
// against hand-written expected vectors for each instruction class.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset;

    multicycle_controller_if bus ();

    multicycle_controller #(.MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Control word: {iord,memwrite,irwrite,pcwrite}, pcsrc, alusrca, alusrcb, alucontrol,
    // {regdst,memtoreg,regwrite,illegal,memerr}
    localparam logic [16:0] F0   = {4'b0000, 2'b00, 1'b0, 2'b01, 3'b101, 5'b00000};
    localparam logic [16:0] F1   = {4'b0011, 2'b00, 1'b0, 2'b01, 3'b101, 5'b00000};
    localparam logic [16:0] FTO  = {4'b0000, 2'b00, 1'b0, 2'b01, 3'b101, 5'b00001};
    localparam logic [16:0] DEC  = {4'b0000, 2'b00, 1'b0, 2'b11, 3'b101, 5'b00000};
    localparam logic [16:0] DILL = {4'b0000, 2'b00, 1'b0, 2'b11, 3'b101, 5'b00010};
    localparam logic [16:0] MADR = {4'b0000, 2'b00, 1'b1, 2'b10, 3'b101, 5'b00000};
    localparam logic [16:0] MRD  = {4'b1000, 2'b00, 1'b0, 2'b00, 3'b101, 5'b00000};
    localparam logic [16:0] MWR  = {4'b1100, 2'b00, 1'b0, 2'b00, 3'b101, 5'b00000};
    localparam logic [16:0] MWTO = {4'b1000, 2'b00, 1'b0, 2'b00, 3'b101, 5'b00001};
    localparam logic [16:0] MWB  = {4'b0000, 2'b00, 1'b0, 2'b00, 3'b101, 5'b01100};
    localparam logic [16:0] AWB  = {4'b0000, 2'b00, 1'b0, 2'b00, 3'b101, 5'b10100};
    localparam logic [16:0] IWB  = {4'b0000, 2'b00, 1'b0, 2'b00, 3'b101, 5'b00100};
    localparam logic [16:0] JMP  = {4'b0001, 2'b10, 1'b0, 2'b00, 3'b101, 5'b00000};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  rt;
        logic        rdy;
        logic        z;
        logic        rst;
        logic [16:0] exp;
    } step_t;

    step_t      q[$];
    logic [5:0] cur_op;
    logic [5:0] cur_funct;
    logic [4:0] cur_rt;
    int         n_vec = 0;
    int         n_err = 0;

    function automatic logic [16:0] obs();
        return {bus.iord, bus.memwrite, bus.irwrite, bus.pcwrite, bus.pcsrc, bus.alusrca,
                bus.alusrcb, bus.alucontrol, bus.regdst, bus.memtoreg, bus.regwrite,
                bus.illegal, bus.memerr};
    endfunction

    function automatic logic [16:0] ex_w(input logic [2:0] alu);
        return {4'b0000, 2'b00, 1'b1, 2'b00, alu, 5'b00000};
    endfunction

    function automatic logic [16:0] br_w(input logic pcw, input logic [2:0] alu);
        return {3'b000, pcw, 2'b01, 1'b1, 2'b00, alu, 5'b00000};
    endfunction

    function automatic logic [16:0] iex_w(input logic [2:0] alu);
        return {4'b0000, 2'b00, 1'b1, 2'b10, alu, 5'b00000};
    endfunction

    task automatic instr(input logic [5:0] op, input logic [5:0] funct, input logic [4:0] rt);
        cur_op = op; cur_funct = funct; cur_rt = rt;
    endtask

    task automatic add(input logic rdy, input logic z, input logic rst, input logic [16:0] exp);
        q.push_back('{cur_op, cur_funct, cur_rt, rdy, z, rst, exp});
    endtask

    task automatic apply(input step_t s);
        bus.op = s.op; bus.funct = s.funct; bus.rt = s.rt;
        bus.memready = s.rdy; bus.zero = s.z; reset = s.rst;
        #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.memready = 1'b1; bus.zero = 1'b0;
        bus.op = 6'h00; bus.funct = 6'h00; bus.rt = 5'd0;
        tick(); tick();
        n_vec++;
        if (obs() !== F0) begin
            n_err++; $display("FAIL reset_hold: got %b want %b", obs(), F0);
        end
        reset = 1'b0; #1;
        n_vec++;
        if (obs() !== F1) begin
            n_err++; $display("FAIL reset_fetch: got %b want %b", obs(), F1);
        end
    endtask

    task automatic test_lw();
        instr(6'h23, 6'h00, 5'd0);
        add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, MADR); add(1, 0, 0, MRD); add(1, 0, 0, MWB);
        foreach (q[i]) begin
            apply(q[i]); n_vec++;
            if (obs() !== q[i].exp) begin
                n_err++; $display("FAIL lw[%0d]: got %b want %b", i, obs(), q[i].exp);
            end
            tick();
        end
        q.delete();
    endtask

    task automatic test_rtype();
        logic [5:0] fn  [5] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2B};
        logic [2:0] alu [5] = '{3'b101, 3'b001, 3'b111, 3'b110, 3'b000};
        for (int k = 0; k < 5; k++) begin
            instr(6'h00, fn[k], 5'd3);
            add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, ex_w(alu[k])); add(1, 0, 0, AWB);
        end
        foreach (q[i]) begin
            apply(q[i]); n_vec++;
            if (obs() !== q[i].exp) begin
                n_err++; $display("FAIL rtype[%0d] funct %h: got %b want %b", i, q[i].funct, obs(), q[i].exp);
            end
            tick();
        end
        q.delete();
    endtask

    task automatic test_branch();
        instr(6'h04, 6'h00, 5'd5);
        add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, br_w(1'b0, 3'b001));
        add(1, 1, 0, F1); add(1, 1, 0, DEC); add(1, 1, 0, br_w(1'b1, 3'b001));
        instr(6'h01, 6'h00, 5'd0);
        add(1, 1, 0, F1); add(1, 1, 0, DEC); add(1, 1, 0, br_w(1'b1, 3'b010));
        add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, br_w(1'b0, 3'b010));
        foreach (q[i]) begin
            apply(q[i]); n_vec++;
            if (obs() !== q[i].exp) begin
                n_err++; $display("FAIL branch[%0d]: got %b want %b", i, obs(), q[i].exp);
            end
            tick();
        end
        q.delete();
    endtask

    task automatic test_imm_jump();
        instr(6'h09, 6'h00, 5'd2); add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, iex_w(3'b101)); add(1, 0, 0, IWB);
        instr(6'h0D, 6'h00, 5'd2); add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, iex_w(3'b110)); add(1, 0, 0, IWB);
        instr(6'h0F, 6'h00, 5'd2); add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, iex_w(3'b011)); add(1, 0, 0, IWB);
        instr(6'h02, 6'h00, 5'd0); add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, JMP);
        foreach (q[i]) begin
            apply(q[i]); n_vec++;
            if (obs() !== q[i].exp) begin
                n_err++; $display("FAIL imm_jump[%0d] op %h: got %b want %b", i, q[i].op, obs(), q[i].exp);
            end
            tick();
        end
        q.delete();
    endtask

    task automatic test_illegal();
        instr(6'h3F, 6'h00, 5'd0); add(1, 0, 0, F1); add(1, 0, 0, DILL);
        instr(6'h01, 6'h00, 5'd1); add(1, 0, 0, F1); add(1, 0, 0, DILL);
        instr(6'h00, 6'h20, 5'd0); add(1, 0, 0, F1); add(1, 0, 0, DILL);
        instr(6'h02, 6'h00, 5'd0); add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, JMP);
        foreach (q[i]) begin
            apply(q[i]); n_vec++;
            if (obs() !== q[i].exp) begin
                n_err++; $display("FAIL illegal[%0d]: got %b want %b", i, obs(), q[i].exp);
            end
            tick();
        end
        q.delete();
    endtask

    task automatic test_sw_stall();
        instr(6'h2B, 6'h00, 5'd4);
        add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, MADR);
        add(0, 0, 0, MWR); add(0, 0, 0, MWR); add(0, 0, 0, MWR); add(1, 0, 0, MWR);
        instr(6'h02, 6'h00, 5'd0);
        add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, JMP);
        foreach (q[i]) begin
            apply(q[i]); n_vec++;
            if (obs() !== q[i].exp) begin
                n_err++; $display("FAIL sw_stall[%0d]: got %b want %b", i, obs(), q[i].exp);
            end
            tick();
        end
        q.delete();
    endtask

    task automatic test_timeouts();
        // Store abort after 15 idle wait cycles, then a clean FETCH.
        instr(6'h2B, 6'h00, 5'd4);
        add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, MADR);
        for (int k = 0; k < 15; k++) add(0, 0, 0, MWR);
        add(0, 0, 0, MWTO);
        instr(6'h02, 6'h00, 5'd0);
        add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, JMP);
        // FETCH timeout retries in FETCH.
        for (int k = 0; k < 15; k++) add(0, 0, 0, F0);
        add(0, 0, 0, FTO);
        add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, JMP);
        // memready arriving on the timeout cycle is a success.
        for (int k = 0; k < 15; k++) add(0, 0, 0, F0);
        add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, JMP);
        foreach (q[i]) begin
            apply(q[i]); n_vec++;
            if (obs() !== q[i].exp) begin
                n_err++; $display("FAIL timeout[%0d]: got %b want %b", i, obs(), q[i].exp);
            end
            tick();
        end
        q.delete();
    endtask

    task automatic test_reset_mid();
        instr(6'h23, 6'h00, 5'd0);
        add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, MADR); add(1, 0, 0, MRD);
        add(1, 0, 1, F0);
        add(1, 0, 0, F1); add(1, 0, 0, DEC); add(1, 0, 0, MADR); add(1, 0, 0, MRD); add(1, 0, 0, MWB);
        foreach (q[i]) begin
            apply(q[i]); n_vec++;
            if (obs() !== q[i].exp) begin
                n_err++; $display("FAIL reset_mid[%0d]: got %b want %b", i, obs(), q[i].exp);
            end
            tick();
        end
        q.delete();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_branch();
        test_imm_jump();
        test_illegal();
        test_sw_stall();
        test_timeouts();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
